// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the d_tile store commit buffer: FSM states, the buffered
// store entry layout and the default geometry.
package store_commit_buffer_pkg;

    localparam int SCB_DEPTH  = 32;
    localparam int SCB_ADDR_W = 32;
    localparam int SCB_DATA_W = 64;
    localparam int SCB_LSID_W = 5;

    typedef logic [SCB_DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } scb_state_t;

    typedef struct packed {
        logic [SCB_ADDR_W-1:0] addr;
        reg_data_t             data;
        logic [SCB_LSID_W-1:0] lsid;
    } scb_entry_t;

endpackage

// File: rtl/store_commit_buffer_fwd_match.sv
// Store-to-load forwarding search over the live entries of the commit buffer.
// Only instantiated when TRIPS_STORE_FWD_EN is defined.
module scb_fwd_match
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH  = SCB_DEPTH,
    parameter int ADDR_W = SCB_ADDR_W,
    parameter int DATA_W = SCB_DATA_W
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_data_i,
    input  logic [$clog2(DEPTH)-1:0]     head_i,
    input  logic [$clog2(DEPTH):0]       count_i,
    input  logic [ADDR_W-1:0]            fwd_addr_i,
    output logic                         fwd_hit_o,
    output logic [DATA_W-1:0]            fwd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Walk live entries oldest to youngest; the last match seen is the youngest
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_i) &&
                (entry_addr_i[head_i + PTR_W'(i)] == fwd_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = entry_data_i[head_i + PTR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds retired stores of the current block until it
// commits, then drains them in order to the D-cache write port.
// Optional store forwarding search is enabled with TRIPS_STORE_FWD_EN.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  COLLECT | accepting retired ops; flush/commit pulses act here
//  DRAIN   | writing held stores to the D-cache, one per handshake
//  DONE    | all stores written; clear load count, pulse commit_done
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH  = SCB_DEPTH,
    parameter int ADDR_W = SCB_ADDR_W,
    parameter int DATA_W = SCB_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ret_valid,
    input  logic                        ret_is_load,
    input  logic [SCB_LSID_W-1:0]       ret_lsid,
    input  logic [ADDR_W-1:0]           ret_addr,
    input  logic [DATA_W-1:0]           ret_data,
    output logic                        ret_ready,
    input  logic                        block_commit,
    input  logic                        block_flush,
    output logic                        mem_wvalid,
    input  logic                        mem_wready,
    output logic [ADDR_W-1:0]           mem_waddr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        commit_done,
    output logic [$clog2(DEPTH):0]      store_count,
    output logic [$clog2(DEPTH):0]      load_count
`ifdef TRIPS_STORE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]           fwd_addr,
    output logic                        fwd_hit,
    output logic [DATA_W-1:0]           fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    scb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic              wvalid_q, wvalid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              st_wr;
    logic              accept;

    scb_entry_t        entry_q [DEPTH];

    assign ret_ready   = (state_q == COLLECT) && (count_q != FULL_CNT);
    assign accept      = ret_valid && ret_ready;
    assign mem_wvalid  = wvalid_q;
    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign commit_done = done_q;
    assign store_count = count_q;
    assign load_count  = load_cnt_q;

    // Entry lsid is kept for debug visibility only; nothing downstream consumes it
    logic unused_lsid;
    assign unused_lsid = ^entry_q[head_q].lsid;

    // Next-state and datapath control for collect / drain / done sequencing
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        load_cnt_d = load_cnt_q;
        wvalid_d   = wvalid_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = (state_q == DONE);
        st_wr      = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (block_flush) begin
                    // Squash wins over a simultaneous commit and over any op retiring now
                    head_d     = '0;
                    tail_d     = '0;
                    count_d    = '0;
                    load_cnt_d = '0;
                end else begin
                    if (accept) begin
                        if (ret_is_load) begin
                            if (load_cnt_q != FULL_CNT) begin
                                load_cnt_d = load_cnt_q + 1'b1;
                            end
                        end else begin
                            st_wr   = 1'b1;
                            tail_d  = tail_q + 1'b1;
                            count_d = count_q + 1'b1;
                        end
                    end
                    // count_d includes a store retiring alongside the commit
                    if (block_commit) begin
                        state_d = (count_d == '0) ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    wvalid_d = 1'b0;
                    state_d  = DONE;
                end else if (!wvalid_q) begin
                    wvalid_d = 1'b1;
                    waddr_d  = entry_q[head_q].addr;
                    wdata_d  = entry_q[head_q].data;
                end else if (mem_wready) begin
                    head_d  = head_q + 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        wvalid_d = 1'b0;
                        state_d  = DONE;
                    end else begin
                        waddr_d = entry_q[head_d].addr;
                        wdata_d = entry_q[head_d].data;
                    end
                end
            end
            DONE: begin
                load_cnt_d = '0;
                state_d    = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Control and output registers; cleared asynchronously, abandoning any drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            load_cnt_q <= '0;
            wvalid_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            load_cnt_q <= load_cnt_d;
            wvalid_q   <= wvalid_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    // Entry storage is not reset; only entries between head and tail are meaningful
    always_ff @(posedge clk) begin
        if (st_wr) begin
            entry_q[tail_q] <= '{addr: ret_addr, data: ret_data, lsid: ret_lsid};
        end
    end

`ifdef TRIPS_STORE_FWD_EN
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;

    // Flatten entry storage for the forwarding search
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] = entry_q[i].addr;
            ent_data[i] = entry_q[i].data;
        end
    end

    scb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd_match (
        .entry_addr_i (ent_addr),
        .entry_data_i (ent_data),
        .head_i       (head_q),
        .count_i      (count_q),
        .fwd_addr_i   (fwd_addr),
        .fwd_hit_o    (fwd_hit),
        .fwd_data_o   (fwd_data)
    );
`endif

`ifndef SYNTHESIS
    logic [SCB_LSID_W-1:0] last_lsid_q;
    logic                  have_lsid_q;

    // Remember the last accepted store lsid of the current block for the order check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_lsid_q <= 1'b0;
            last_lsid_q <= '0;
        end else if ((block_flush && state_q == COLLECT) || state_q == DONE) begin
            have_lsid_q <= 1'b0;
        end else if (accept && !ret_is_load) begin
            have_lsid_q <= 1'b1;
            last_lsid_q <= ret_lsid;
        end
    end

    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
        ret_valid |-> ret_ready);

    a_lsid_order: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && !ret_is_load && !block_flush && have_lsid_q) |-> (ret_lsid > last_lsid_q));

    a_no_pulse_in_drain: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == DRAIN) |-> !(block_commit || block_flush));
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer. Retire ops come from a vector
// table; expected D-cache writes go into a scoreboard queue and are checked by
// a monitor on every handshake. Define TRIPS_STORE_FWD_EN to cover forwarding.
module tb_store_commit_buffer;

    logic        clk;
    logic        rst_n;
    logic        ret_valid;
    logic        ret_is_load;
    logic [4:0]  ret_lsid;
    logic [31:0] ret_addr;
    logic [63:0] ret_data;
    logic        ret_ready;
    logic        block_commit;
    logic        block_flush;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        commit_done;
    logic [5:0]  store_count;
    logic [5:0]  load_count;
`ifdef TRIPS_STORE_FWD_EN
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [63:0] fwd_data;
`endif

    store_commit_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ret_valid    (ret_valid),
        .ret_is_load  (ret_is_load),
        .ret_lsid     (ret_lsid),
        .ret_addr     (ret_addr),
        .ret_data     (ret_data),
        .ret_ready    (ret_ready),
        .block_commit (block_commit),
        .block_flush  (block_flush),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .commit_done  (commit_done),
        .store_count  (store_count),
        .load_count   (load_count)
`ifdef TRIPS_STORE_FWD_EN
        ,
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
`endif
    );

    typedef struct {
        logic        is_load;
        logic [4:0]  lsid;
        logic [31:0] addr;
        logic [63:0] data;
        int          exp_sc;
        int          exp_lc;
    } vec_t;

    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
    } wr_t;

    vec_t vt [12];
    wr_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic ld, input logic [4:0] lsid,
                          input logic [31:0] a, input logic [63:0] d);
        ret_valid   = 1'b1;
        ret_is_load = ld;
        ret_lsid    = lsid;
        ret_addr    = a;
        ret_data    = d;
        tick();
        ret_valid   = 1'b0;
        ret_is_load = 1'b0;
        if (!ld) sb.push_back('{a: a, d: d});
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            chk($sformatf("vec%0d_ready", i), ret_ready, 1);
            retire(vt[i].is_load, vt[i].lsid, vt[i].addr, vt[i].data);
            chk($sformatf("vec%0d_store_count", i), store_count, vt[i].exp_sc);
            chk($sformatf("vec%0d_load_count", i), load_count, vt[i].exp_lc);
        end
    endtask

    task automatic drain_block(input string name, input int exp_writes, input bit toggle);
        int w0;
        bit seen;
        seen = 1'b0;
        w0   = n_writes;
        block_commit = 1'b1;
        tick();
        block_commit = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (toggle) mem_wready = ~mem_wready;
            tick();
            if (commit_done) seen = 1'b1;
        end
        mem_wready = 1'b1;
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_nwrites"}, n_writes - w0, exp_writes);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_store_count"}, store_count, 0);
        tick();
        chk({name, "_done_single"}, commit_done, 0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit any_wv;
        any_wv = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (mem_wvalid) any_wv = 1'b1;
        end
        chk({name, "_no_wvalid"}, any_wv, 0);
    endtask

    // Write-port monitor: scoreboard compare on handshake, hold check on stall
    initial begin
        bit          stalled;
        logic [31:0] st_a;
        logic [63:0] st_d;
        wr_t         e;
        stalled = 1'b0;
        st_a    = '0;
        st_d    = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stalled) begin
                    chk("stall_wvalid_held", mem_wvalid, 1);
                    chk("stall_addr_held", mem_waddr, st_a);
                    chk("stall_data_held", mem_wdata, st_d);
                end
                stalled = mem_wvalid && !mem_wready;
                st_a    = mem_waddr;
                st_d    = mem_wdata;
                if (mem_wvalid && mem_wready) begin
                    n_writes++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                                 mem_waddr, mem_wdata);
                    end else begin
                        e = sb.pop_front();
                        chk("write_addr", mem_waddr, e.a);
                        chk("write_data", mem_wdata, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0]  = '{1'b0, 5'd2, 32'h100, 64'hA, 1, 0};
        vt[1]  = '{1'b0, 5'd5, 32'h104, 64'hB, 2, 0};
        vt[2]  = '{1'b0, 5'd9, 32'h108, 64'hC, 3, 0};
        vt[3]  = '{1'b0, 5'd1, 32'h300, 64'h30, 1, 0};
        vt[4]  = '{1'b0, 5'd2, 32'h304, 64'h31, 2, 0};
        vt[5]  = '{1'b0, 5'd3, 32'h308, 64'h32, 3, 0};
        vt[6]  = '{1'b0, 5'd4, 32'h30C, 64'h33, 4, 0};
        vt[7]  = '{1'b0, 5'd0, 32'h400, 64'h0123_4567_89AB_CDEF, 1, 0};
        vt[8]  = '{1'b1, 5'd6, 32'h0, 64'h0, 0, 1};
        vt[9]  = '{1'b1, 5'd7, 32'h0, 64'h0, 0, 2};
        vt[10] = '{1'b0, 5'd3, 32'h500, 64'h55, 1, 0};
        vt[11] = '{1'b0, 5'd4, 32'h504, 64'h56, 2, 0};

        rst_n        = 1'b0;
        ret_valid    = 1'b0;
        ret_is_load  = 1'b0;
        ret_lsid     = '0;
        ret_addr     = '0;
        ret_data     = '0;
        block_commit = 1'b0;
        block_flush  = 1'b0;
        mem_wready   = 1'b1;
`ifdef TRIPS_STORE_FWD_EN
        fwd_addr     = '0;
`endif
        tick();
        tick();
        chk("rst_ret_ready", ret_ready, 1);
        chk("rst_wvalid", mem_wvalid, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_commit_done", commit_done, 0);
        chk("rst_store_count", store_count, 0);
        chk("rst_load_count", load_count, 0);
        rst_n = 1'b1;
        tick();

        // Three stores, commit, back-to-back writes with exact latency
        apply(0, 2);
        block_commit = 1'b1;
        tick();
        block_commit = 1'b0;
        chk("b1_wvalid_at_commit_edge", mem_wvalid, 0);
        tick();
        chk("b1_wvalid_w0", mem_wvalid, 1);
        chk("b1_addr_w0", mem_waddr, 32'h100);
        tick();
        chk("b1_wvalid_w1", mem_wvalid, 1);
        chk("b1_addr_w1", mem_waddr, 32'h104);
        tick();
        chk("b1_wvalid_w2", mem_wvalid, 1);
        chk("b1_addr_w2", mem_waddr, 32'h108);
        tick();
        chk("b1_wvalid_drop", mem_wvalid, 0);
        chk("b1_done_early", commit_done, 0);
        tick();
        chk("b1_done", commit_done, 1);
        chk("b1_store_count", store_count, 0);
        tick();
        chk("b1_done_single", commit_done, 0);
        chk("b1_sb_empty", sb.size(), 0);

        // Four stores then flush: nothing written
        apply(3, 6);
        block_flush = 1'b1;
        tick();
        block_flush = 1'b0;
        sb.delete();
        chk("b2_store_count", store_count, 0);
        chk("b2_ready", ret_ready, 1);
        expect_quiet("b2", 6);

        // One-store block after the flush
        apply(7, 7);
        drain_block("b3", 1, 1'b0);

        // Full buffer starting at head=tail=1, drained with back-pressure across the wrap
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("full_ready%0d", i), ret_ready, 1);
            retire(1'b0, 5'(i), 32'h1000 + 32'(4 * i), {32'(i), ~32'(i)});
        end
        chk("full_ready_low", ret_ready, 0);
        chk("full_store_count", store_count, 32);
        drain_block("full", 32, 1'b1);
        chk("full_ready_after", ret_ready, 1);

        // Commit with no stores but two loads
        apply(8, 9);
        block_commit = 1'b1;
        tick();
        block_commit = 1'b0;
        chk("ld_done_early", commit_done, 0);
        chk("ld_count_before", load_count, 2);
        tick();
        chk("ld_done", commit_done, 1);
        chk("ld_count_after", load_count, 0);
        tick();
        chk("ld_done_single", commit_done, 0);
        chk("ld_no_writes", sb.size(), 0);

        // Commit and flush together: flush wins
        apply(10, 11);
        block_commit = 1'b1;
        block_flush  = 1'b1;
        tick();
        block_commit = 1'b0;
        block_flush  = 1'b0;
        sb.delete();
        chk("cf_store_count", store_count, 0);
        expect_quiet("cf", 6);
        chk("cf_no_done", commit_done, 0);
        chk("cf_ready", ret_ready, 1);

        // Load counter saturates at 32
        for (int i = 0; i < 34; i++) retire(1'b1, 5'(i), 32'h0, 64'h0);
        chk("ld_saturate", load_count, 32);
        block_flush = 1'b1;
        tick();
        block_flush = 1'b0;
        chk("ld_flush_clear", load_count, 0);

`ifdef TRIPS_STORE_FWD_EN
        retire(1'b0, 5'd1, 32'h200, 64'h11);
        retire(1'b0, 5'd2, 32'h200, 64'h22);
        fwd_addr = 32'h200;
        #1;
        chk("fwd_hit", fwd_hit, 1);
        chk("fwd_data_youngest", fwd_data, 64'h22);
        fwd_addr = 32'h204;
        #1;
        chk("fwd_miss", fwd_hit, 0);
        chk("fwd_miss_data", fwd_data, 0);
        block_flush = 1'b1;
        tick();
        block_flush = 1'b0;
        sb.delete();
        fwd_addr = 32'h200;
        #1;
        chk("fwd_after_flush", fwd_hit, 0);
`endif

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_commit_buffer.md
Name: store_commit_buffer

Overview:
- Sits directly downstream of the LSID unit inside the d_tile.
- Captures stores that retire from the LSID unit in LSID order and holds them speculatively until the owning block commits. It then drains them in order to the data-cache write port over a valid/ready handshake.
- Block flush discards all held stores. Loads on the commit stream are counted but not buffered.

Parameters:
DEPTH, 32, store entries (one per LSID); power of two
ADDR_W, 32, address width
DATA_W, 64, store data width; equals width of reg_data_t

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ret_valid  in  1  retired op from LSID unit (its ack)
ret_is_load  in  1  1 = load (counted, not stored)
ret_lsid  in  5  LSID of retired op
ret_addr  in  ADDR_W  store address
ret_data  in  DATA_W  store data
ret_ready  out  1  buffer can accept a retired op
block_commit  in  1  single-cycle pulse: block committed, release stores
block_flush  in  1  single-cycle pulse: block squashed, discard stores
mem_wvalid  out  1  write request to D-cache
mem_wready  in  1  D-cache accepts write
mem_waddr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
commit_done  out  1  one-cycle pulse: all stores of committed block written
store_count  out  6  stores currently held (0..32)
load_count  out  6  loads retired in current block (saturates at 32)

Behaviour:
- Reset (async, rst_n low): state=COLLECT; head=tail=0; count=0; load_count=0; mem_wvalid=0; mem_waddr=0; mem_wdata=0; commit_done=0; ret_ready=1. Entry contents are not reset.
- Storage: circular FIFO of DEPTH entries {addr, data, lsid}. Pointers are 5-bit and wrap mod DEPTH. count is 6-bit; full when count==DEPTH.
- ret_ready = (state==COLLECT) && !full. Combinational from registered state.
- Accept: ret_valid && ret_ready.
  - Store: write entry at tail, tail++, count++ at the next edge.
  - Load: load_count++ (saturating); no entry written.
- ret_valid while !ret_ready: op is dropped. An assertion fires in simulation; the LSID unit guarantees this never occurs.
- LSID order check: each accepted store's lsid must be greater than the previous accepted store's lsid within the block. Violation fires an assertion only; there is no functional effect.
- State machine:
  - COLLECT:
    - block_flush: head=tail=0, count=0, load_count=0; stay in COLLECT.
    - block_commit: go to DRAIN; if count==0, go to DONE instead.
    - Both pulses in the same cycle: flush wins, and the commit is ignored.
    - A retired op arriving in the same cycle as block_commit is accepted and drained with the block.
  - DRAIN:
    - mem_wvalid=1; mem_waddr/mem_wdata registered from head entry.
    - On mem_wvalid && mem_wready: head++, count--. If the new count==0, drop mem_wvalid and go to DONE. Otherwise present the next entry the following cycle: one write per cycle maximum, and mem_wvalid stays high between entries.
    - Outputs stay stable while mem_wvalid && !mem_wready.
    - block_flush and block_commit are ignored, and an assertion fires.
  - DONE: commit_done=1 for exactly one cycle; load_count cleared; go to COLLECT.
- Latency:
  - block_commit at edge N → first mem_wvalid visible after edge N+1.
  - Last handshake at edge M → commit_done high in cycle M+1.
- Wrap-around: pointers wrap at 31→0. A full buffer (32 stores) drains all 32 entries correctly.
- Reset mid-DRAIN: everything is cleared immediately; partially drained stores are lost by design, since the block is re-fetched.

Optional Feature:
- Macro: TRIPS_STORE_FWD_EN.
- Enabled: adds ports fwd_addr (in, ADDR_W), fwd_hit (out, 1), fwd_data (out, DATA_W).
  - Combinational search of valid entries for an exact address match; the youngest matching entry wins.
  - fwd_hit=1 and fwd_data = that entry's data; otherwise fwd_hit=0 and fwd_data=0.
  - Valid while in COLLECT or DRAIN; entries already drained do not match.
- Disabled: ports absent; no search logic.

Decomposition:
- Shared package (trips types): scb_state_t enum {COLLECT, DRAIN, DONE}; scb_entry_t packed struct {addr, data, lsid}; SCB_DEPTH=32 constant.
- One sub-module, scb_fwd_match: priority match over entries, instantiated only under TRIPS_STORE_FWD_EN.

Test Plan:
- 3 stores (lsid 2,5,9; addr 0x100,0x104,0x108; data 0xA,0xB,0xC), mem_wready=1, then commit → three writes in order on consecutive cycles; commit_done one cycle after the third write; store_count=0.
- 4 stores, then flush → no mem_wvalid ever; store_count=0; next block of 1 store, then commit → single write of the new data.
- 32 stores → ret_ready=0 after the 32nd. Commit with mem_wready toggled 1/0 → 32 writes in order, outputs held during stall cycles, pointers wrap.
- Commit with 0 stores and 2 loads → commit_done two cycles after the commit pulse; load_count=2 before, 0 after; no writes.
- Commit and flush in the same cycle with 2 stores held → treated as flush, no writes. A separate commit during DRAIN → ignored, assertion fires.
- (FWD_EN) stores 0x200←0x11 then 0x200←0x22; fwd_addr=0x200 → hit, 0x22. fwd_addr=0x204 → hit=0.
